// File: rtl/ccff_loader_pkg.sv
// Shared types and sizing helpers for the CCFF chain loader.
// Used by the loader FSM and its image buffer.
package ccff_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    SHIFT,
    VERIFY,
    DONE
  } state_e;

  function automatic int cw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int nwords(input int len, input int w);
    return (len + w - 1) / w;
  endfunction

endpackage

// File: rtl/ccff_image_buffer.sv
// Word-write / bit-read register file holding one chain image.
// Bits past CHAIN_LEN in the last word have no storage.
module ccff_image_buffer
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 18,
  parameter int WORD_W    = 8,
  parameter int NWORDS    = 3,
  parameter int WCW       = 2,
  parameter int BCW       = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              we,
  input  logic [WCW-1:0]    waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [BCW-1:0]    raddr,
  output logic              rbit
);

  localparam int DEPTH = 1 << BCW;

  logic [CHAIN_LEN-1:0] mem;
  logic [DEPTH-1:0]     ext;

  for (genvar b = 0; b < CHAIN_LEN; b++) begin : g_bit
    localparam int K = b / WORD_W;
    localparam int J = b % WORD_W;
    logic q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q <= 1'b0;
      end else if (clr) begin
        q <= 1'b0;
      end else if (we && waddr == WCW'(K)) begin
        q <= wdata[J];
      end
    end
    assign mem[b] = q;
  end

  // Zero-pad so any counter value is a legal index.
  assign ext  = {{(DEPTH - CHAIN_LEN){1'b0}}, mem};
  assign rbit = ext[raddr];

endmodule

// File: rtl/ccff_chain_loader.sv
// Buffers one chain image, shifts it into a CCFF chain, then
// re-shifts it while checking the tail bit-for-bit.
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 18,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              start,
  input  logic              abort,
  input  logic              s_valid,
  input  logic [WORD_W-1:0] s_data,
  output logic              s_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              config_enable,
  output logic              config_readback,
  output logic              busy,
  output logic              done,
  output logic              fail
);

  localparam int NWORDS = nwords(CHAIN_LEN, WORD_W);
  localparam int BCW    = cw(CHAIN_LEN + 1);
  localparam int WCW    = cw(NWORDS + 1);

  localparam logic [BCW-1:0] BIT_LAST  = BCW'(CHAIN_LEN - 1);
  localparam logic [WCW-1:0] WORD_LAST = WCW'(NWORDS - 1);

  state_e         state, state_nx;
  logic [BCW-1:0] bit_cnt, bit_nx;
  logic [WCW-1:0] word_cnt, word_nx;
  logic           fail_q, fail_nx;
  logic           clr, we, rbit;

  ccff_image_buffer #(
    .CHAIN_LEN(CHAIN_LEN),
    .WORD_W   (WORD_W),
    .NWORDS   (NWORDS),
    .WCW      (WCW),
    .BCW      (BCW)
  ) u_buf (
    .clk  (prog_clk),
    .rst_n(pReset_n),
    .clr  (clr),
    .we   (we),
    .waddr(word_cnt),
    .wdata(s_data),
    .raddr(bit_cnt),
    .rbit (rbit)
  );

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      word_cnt <= '0;
      fail_q   <= 1'b0;
    end else begin
      state    <= state_nx;
      bit_cnt  <= bit_nx;
      word_cnt <= word_nx;
      fail_q   <= fail_nx;
    end
  end

  always_comb begin
    state_nx        = state;
    bit_nx          = bit_cnt;
    word_nx         = word_cnt;
    fail_nx         = fail_q;
    clr             = 1'b0;
    we              = 1'b0;
    s_ready         = 1'b0;
    ccff_head       = 1'b0;
    config_enable   = 1'b0;
    config_readback = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nx = FILL;
          clr      = 1'b1;
          word_nx  = '0;
          bit_nx   = '0;
          fail_nx  = 1'b0;
        end
      end
      FILL: begin
        s_ready = 1'b1;
        if (s_valid) begin
          we      = 1'b1;
          word_nx = word_cnt + WCW'(1);
          if (word_cnt == WORD_LAST) begin
            state_nx = SHIFT;
            bit_nx   = '0;
          end
        end
      end
      SHIFT: begin
        config_enable = 1'b1;
        ccff_head     = rbit;
        if (bit_cnt == BIT_LAST) begin
          state_nx = VERIFY;
          bit_nx   = '0;
        end else begin
          bit_nx = bit_cnt + BCW'(1);
        end
      end
      VERIFY: begin
        config_enable   = 1'b1;
        config_readback = 1'b1;
        ccff_head       = rbit;
        if (ccff_tail != rbit) fail_nx = 1'b1;
        if (bit_cnt == BIT_LAST) begin
          state_nx = DONE;
          bit_nx   = '0;
        end else begin
          bit_nx = bit_cnt + BCW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
    // Abort wins over start and over a pending word transfer.
    if (abort) begin
      state_nx = IDLE;
      bit_nx   = '0;
      word_nx  = '0;
      fail_nx  = 1'b0;
      clr      = 1'b0;
      we       = 1'b0;
      s_ready  = 1'b0;
    end
  end

  assign busy = (state == FILL) || (state == SHIFT) || (state == VERIFY);
  assign done = (state == DONE);
  assign fail = fail_q;

endmodule

// File: doc/ccff_chain_loader.md
Name: ccff_chain_loader

Overview:
- Upstream driver of a logic tile's configuration-chain (CCFF) memory: accepts bitstream words over a valid/ready stream, buffers one full chain image and serially shifts it into ccff_head while driving config_enable.
- Second pass re-shifts the same image and checks ccff_tail bit-for-bit; the chain ends with identical contents and a pass/fail flag.
- Sits between the PMU bitstream source and one tile chain, e.g. the 18-bit frac_lut4_arith chain: 16 sram bits plus 2 mode bits.

Parameters:
- CHAIN_LEN, 18, number of CCFF stages in the target chain (2..256).
- WORD_W, 8, input word width (1..32).
- NWORDS, ceil(CHAIN_LEN/WORD_W), derived localparam; words per image.

Ports:
- prog_clk  in  1  programming clock; all state on rising edge.
- pReset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins load when IDLE or DONE, ignored otherwise.
- abort  in  1  one-cycle pulse; return to IDLE from any state.
- s_valid  in  1  input word valid.
- s_data  in  WORD_W  bitstream word; bit 0 is shifted first.
- s_ready  out  1  loader accepts a word this cycle.
- ccff_head  out  1  serial data to the chain head.
- ccff_tail  in  1  serial data from the chain tail.
- config_enable  out  1  chain shift enable.
- config_readback  out  1  high during the verify pass.
- busy  out  1  high in FILL/SHIFT/VERIFY.
- done  out  1  high in DONE.
- fail  out  1  sticky mismatch flag, valid when done=1.

Behaviour:
- Reset: state IDLE; s_ready, ccff_head, config_enable, config_readback, busy, done, fail all 0; buffer, bit and word counters cleared.
- States: IDLE, FILL, SHIFT, VERIFY, DONE.
- IDLE/DONE, start=1 -> FILL next cycle. Entering FILL clears fail, the word counter and the buffer.
- FILL: s_ready=1. Transfer only when s_valid&s_ready. Word k fills buffer bits [k*WORD_W +: WORD_W]. Bits at or beyond CHAIN_LEN in the last word are discarded. After the NWORDS-th transfer -> SHIFT; s_ready drops on the next cycle.
- SHIFT: config_enable=1 for exactly CHAIN_LEN cycles; ccff_head = buffer[i] in cycle i (i = 0..CHAIN_LEN-1). Counter i is registered and ccff_head is driven combinationally from buffer[i] with no extra latency. After i=CHAIN_LEN-1 -> VERIFY with i=0.
- VERIFY: config_enable=1 and config_readback=1 for CHAIN_LEN cycles; ccff_head = buffer[i] again.
  - On each rising edge in VERIFY, sample ccff_tail and compare it with buffer[i]. Any inequality sets fail.
  - After the last cycle -> DONE; config_enable and config_readback drop.
- DONE: done=1 and holds until start or abort.
- config_enable is never high outside SHIFT/VERIFY. There is no gap cycle between the two passes: 2*CHAIN_LEN contiguous enable cycles.
- abort has priority over start and over a simultaneous word transfer. Next state is IDLE, all outputs return to reset values, and a partial chain image is left in the chain. A start pulse in the same cycle is ignored.
- start while busy: ignored.
- s_valid while not in FILL: no transfer; s_ready=0.
- Counters: bit counter ceil(log2(CHAIN_LEN+1)) bits; word counter ceil(log2(NWORDS+1)) bits. Neither wraps; terminal counts end the state.
- Reset asserted mid-operation: immediate asynchronous return to reset values. No further config_enable edges occur.

Decomposition:
- Shared package ccff_loader_pkg: state enum (IDLE, FILL, SHIFT, VERIFY, DONE), a clog2-based width function, and the NWORDS derivation.
- One natural sub-module, ccff_image_buffer: word-write / bit-read register file of CHAIN_LEN bits with a clear input.
- FSM, counters and comparator stay in ccff_chain_loader.

Test Plan:
- Nominal load: CHAIN_LEN=18, WORD_W=8, words 0xA5, 0x3C, 0x02 with a behavioural 18-stage shift-register chain model.
  - ccff_head sequence in SHIFT is 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 0,1.
  - config_enable is high for exactly 36 cycles; done=1, fail=0.
  - Model chain holds the image.
- Backpressure: s_valid toggled 1-0-1-0 during FILL. Exactly 3 transfers occur, the buffer equals the nominal image, and the SHIFT output is identical to the nominal case.
- Fault injection: chain model stage 5 stuck-at-1 with a bit value of 0 at that position -> fail=1 at DONE, done=1.
- Abort mid-SHIFT at i=7 -> next cycle state IDLE, config_enable=0, busy=0. A following start plus 3 words completes with fail=0.
- Async reset: pReset_n low mid-VERIFY for half a cycle -> all outputs 0 immediately, without waiting for a clock edge; no enable pulses until a new start.
- Edge parameters: CHAIN_LEN=16, WORD_W=16, one word 0xFFFF. Exactly 1 transfer, 32 enable cycles, fail=0. start pulsed during busy is ignored.
